data_memory_ctrl: RTL and testbench

- Next-generation data memory for the RISC-V CPU: parametrised depth, configurable wait-state latency and a req/ack handshake.
- Supports byte, half and word loads and stores, with sign or zero extension on loads, plus misalignment detection.
- Sits between the MEM stage / multi-cycle controller and the word-organised storage array. It supersedes the single-cycle DataMemory.

---
 rtl/dm_pkg.sv | 54 +++++
 rtl/dm_lane_align.sv | 47 ++++
 rtl/data_memory_ctrl.sv | 128 ++++++++++++
 tb/tb_data_memory_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data memory controller.
// Holds the access-size encodings, the controller state type, and the
// helper functions for misalignment checks, byte-enable generation and
// load-lane extraction/extension.
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_ERR
  } dm_state_t;

  // Any access that does not fit inside one naturally aligned word is
  // rejected. The reserved size code is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = off[0];
      SZ_W:    is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size,
                                         input logic [1:0] off);
    case (size)
      SZ_B:    byte_en = 4'b0001 << off;
      SZ_H:    byte_en = {off[1], off[1], ~off[1], ~off[1]};
      SZ_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Shift the addressed lane(s) down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        sgn);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_H:    load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering for the data memory controller.
// Ports:
//   i_size   access size code
//   i_off    byte offset inside the word (address bits [1:0])
//   i_signed sign-extend sub-word loads
//   i_wdata  right-aligned store data
//   i_rword  current contents of the addressed word
//   o_be     byte enables of the store
//   o_wword  merged word to write back (read-modify-write)
//   o_rdata  extracted and extended load result
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata
);

  logic [31:0] w_rep;

  // Replicate sub-word store data across all lanes so the byte enables
  // alone pick the destination lane.
  always_comb begin
    case (i_size)
      SZ_B:    w_rep = {4{i_wdata[7:0]}};
      SZ_H:    w_rep = {2{i_wdata[15:0]}};
      default: w_rep = i_wdata;
    endcase
  end

  assign o_be = byte_en(i_size, i_off);

  always_comb begin
    o_wword = i_rword;
    for (int i = 0; i < 4; i++) begin
      if (o_be[i]) o_wword[8*i +: 8] = w_rep[8*i +: 8];
    end
  end

  assign o_rdata = load_extend(i_rword, i_size, i_off, i_signed);

endmodule

// File: rtl/data_memory_ctrl.sv
// Multi-cycle data memory with req/ack handshake and wait states.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   req      access request, only looked at while idle
//   DMwr     1 = store, 0 = load
//   DMaddr   byte address (wraps modulo DEPTH*4)
//   DMin     right-aligned store data
//   DMsize   00 byte, 01 half, 10 word, 11 reserved (rejected)
//   DMsigned sign-extend sub-word loads
//   busy     high whenever the controller is not idle
//   ack      one-cycle completion pulse
//   misalign with ack: access was rejected and had no effect
//   DMout    load result, held until the next completed load
module data_memory_ctrl
  import dm_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        DMwr,
  input  logic [31:0] DMaddr,
  input  logic [31:0] DMin,
  input  logic [1:0]  DMsize,
  input  logic        DMsigned,
  output logic        busy,
  output logic        ack,
  output logic        misalign,
  output logic [31:0] DMout
);

  localparam int ADDR_W = $clog2(DEPTH);

  dm_state_t r_state, w_next;
  logic [3:0]        r_cnt;
  logic [31:0]       r_dout;

  logic              r_wr;
  logic [ADDR_W-1:0] r_idx;
  logic [1:0]        r_off;
  logic [31:0]       r_din;
  logic [1:0]        r_size;
  logic              r_signed;

  logic [31:0]       r_mem [DEPTH];

  logic              w_accept;
  logic              w_commit;
  logic              w_mis;
  logic [31:0]       w_rword;
  logic [31:0]       w_wword;
  logic [31:0]       w_rdata;
  logic [3:0]        w_be;
  logic              w_unused_addr;

  // Address bits above the word index are deliberately ignored.
  assign w_unused_addr = ^DMaddr[31:ADDR_W+2];

  assign w_accept = (r_state == ST_IDLE) && req;
  assign w_mis    = is_misaligned(DMsize, DMaddr[1:0]);
  // The access takes effect on the edge that leaves the last wait cycle.
  assign w_commit = (r_state == ST_WAIT) && (r_cnt == 4'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req) w_next = w_mis ? ST_ERR : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0) w_next = ST_ACK;
      ST_ACK:  w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_dout  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt <= 4'(LATENCY);
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit && !r_wr) r_dout <= w_rdata;
    end
  end

  // Request fields are frozen at accept so the requester may move on.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wr     <= DMwr;
      r_idx    <= DMaddr[ADDR_W+1:2];
      r_off    <= DMaddr[1:0];
      r_din    <= DMin;
      r_size   <= DMsize;
      r_signed <= DMsigned;
    end
  end

  assign w_rword = r_mem[r_idx];

  always_ff @(posedge clk) begin
    if (w_commit && r_wr) r_mem[r_idx] <= w_wword;
  end

  dm_lane_align u_align (
    .i_size   (r_size),
    .i_off    (r_off),
    .i_signed (r_signed),
    .i_wdata  (r_din),
    .i_rword  (w_rword),
    .o_be     (w_be),
    .o_wword  (w_wword),
    .o_rdata  (w_rdata)
  );

  assign busy     = (r_state != ST_IDLE);
  assign ack      = (r_state == ST_ACK) || (r_state == ST_ERR);
  assign misalign = (r_state == ST_ERR);
  assign DMout    = r_dout;

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] din;
  logic [1:0]  size;
  logic        sgn;
  logic        sel;

  logic        busy1, ack1, mis1;
  logic [31:0] dout1;
  logic        busy2, ack2, mis2;
  logic [31:0] dout2;

  logic        busy, ack, mis;
  logic [31:0] dout;

  int errors = 0;
  int checks = 0;

  // Byte-addressed image of the DEPTH=1024 instance (4096 bytes).
  logic [7:0] mb [0:4095];

  initial clk = 1'b1;
  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req(req & ~sel), .DMwr(wr), .DMaddr(addr),
    .DMin(din), .DMsize(size), .DMsigned(sgn),
    .busy(busy1), .ack(ack1), .misalign(mis1), .DMout(dout1)
  );

  data_memory_ctrl #(.DEPTH(16), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req(req & sel), .DMwr(wr), .DMaddr(addr),
    .DMin(din), .DMsize(size), .DMsigned(sgn),
    .busy(busy2), .ack(ack2), .misalign(mis2), .DMout(dout2)
  );

  assign busy = sel ? busy2 : busy1;
  assign ack  = sel ? ack2  : ack1;
  assign mis  = sel ? mis2  : mis1;
  assign dout = sel ? dout2 : dout1;

  function automatic logic model_mis(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] s);
    int nb = 1 << s;
    for (int i = 0; i < nb; i++) mb[(int'(a[11:0]) + i) % 4096] = d[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s,
                                             input logic g);
    int nb = 1 << s;
    logic [31:0] v = 32'd0;
    for (int i = 0; i < nb; i++) v = v | (32'(mb[(int'(a[11:0]) + i) % 4096]) << (8*i));
    if (g && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
    return v;
  endfunction

  // One access: wait for idle, present, release after accept (scrambling the
  // inputs), then count cycles until ack. lat=0 means ack never came.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input logic g,
                        output int lat, output logic m, output logic [31:0] o);
    int n = 0;
    while (busy && n < 50) begin @(posedge clk); #1; n++; end
    wr = w; addr = a; din = d; size = s; sgn = g; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; wr = 1'($urandom); addr = $urandom; din = $urandom;
    size = 2'($urandom); sgn = 1'($urandom);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (ack) begin lat = k; break; end
      @(posedge clk); #1;
    end
    m = mis; o = dout;
  endtask

  task automatic test_reset();
    int lat; logic m; logic [31:0] o;
    rst = 1'b0; req = 1'b0; sel = 1'b0; wr = 1'b0; addr = '0; din = '0; size = '0; sgn = 1'b0;
    #20;
    checks++; if (busy1 !== 1'b0 || ack1 !== 1'b0 || mis1 !== 1'b0) begin
      errors++; $display("FAIL rst_ctrl: busy=%b ack=%b mis=%b expected 000", busy1, ack1, mis1); end
    checks++; if (dout1 !== 32'd0) begin
      errors++; $display("FAIL rst_dout: got %h expected 00000000", dout1); end
    #5 rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (busy1 !== 1'b0 || ack1 !== 1'b0 || dout1 !== 32'd0) begin
      errors++; $display("FAIL idle_after_rst: busy=%b ack=%b dout=%h", busy1, ack1, dout1); end
    // Reset in the middle of a store must abort it.
    access(1'b1, 32'h3C, 32'hDEADBEEF, 2'd2, 1'b0, lat, m, o);
    model_store(32'h3C, 32'hDEADBEEF, 2'd2);
    checks++; if (lat !== 4) begin errors++; $display("FAIL pre_sw_lat: got %0d expected 4", lat); end
    @(posedge clk); #1;
    wr = 1'b1; addr = 32'h3C; din = 32'h12345678; size = 2'd2; sgn = 1'b0; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #2; rst = 1'b0; #1;
    checks++; if (busy1 !== 1'b0 || ack1 !== 1'b0 || dout1 !== 32'd0) begin
      errors++; $display("FAIL midop_rst: busy=%b ack=%b dout=%h", busy1, ack1, dout1); end
    @(negedge clk); rst = 1'b1;
    repeat (4) @(posedge clk); #1;
    access(1'b0, 32'h3C, 32'h0, 2'd2, 1'b0, lat, m, o);
    checks++; if (o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL aborted_store: got %h expected deadbeef", o); end
  endtask

  task automatic test_word();
    int lat; logic m; logic [31:0] o;
    access(1'b1, 32'h3C, 32'h12345678, 2'd2, 1'b0, lat, m, o);
    model_store(32'h3C, 32'h12345678, 2'd2);
    checks++; if (lat !== 4 || m !== 1'b0) begin
      errors++; $display("FAIL sw_ack: lat=%0d mis=%b expected 4/0", lat, m); end
    access(1'b0, 32'h3C, 32'h0, 2'd2, 1'b1, lat, m, o);
    checks++; if (lat !== 4 || m !== 1'b0) begin
      errors++; $display("FAIL lw_ack: lat=%0d mis=%b expected 4/0", lat, m); end
    checks++; if (o !== 32'h12345678) begin
      errors++; $display("FAIL lw_data: got %h expected 12345678", o); end
    repeat (3) @(posedge clk); #1;
    checks++; if (dout1 !== 32'h12345678) begin
      errors++; $display("FAIL dout_hold: got %h expected 12345678", dout1); end
  endtask

  task automatic test_subword();
    int lat; logic m; logic [31:0] o; logic [31:0] d;
    access(1'b1, 32'h40, 32'h12345678, 2'd2, 1'b0, lat, m, o);
    d = $urandom; d[7:0] = 8'hAB;
    access(1'b1, 32'h41, d, 2'd0, 1'b0, lat, m, o);
    checks++; if (lat !== 4 || o !== 32'h12345678) begin
      errors++; $display("FAIL sb_ack: lat=%0d dout=%h expected 4/12345678", lat, o); end
    d = $urandom; d[15:0] = 16'hCDEF;
    access(1'b1, 32'h42, d, 2'd1, 1'b0, lat, m, o);
    model_store(32'h40, 32'hCDEFAB78, 2'd2);
    access(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, lat, m, o);
    checks++; if (o !== 32'hCDEFAB78) begin
      errors++; $display("FAIL subword_merge: got %h expected cdefab78", o); end
  endtask

  task automatic test_extension();
    int lat; logic m; logic [31:0] o;
    access(1'b1, 32'h44, 32'h80FF7F01, 2'd2, 1'b0, lat, m, o);
    model_store(32'h44, 32'h80FF7F01, 2'd2);
    access(1'b0, 32'h46, 32'h0, 2'd0, 1'b1, lat, m, o);
    checks++; if (o !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb: got %h expected ffffffff", o); end
    access(1'b0, 32'h47, 32'h0, 2'd0, 1'b0, lat, m, o);
    checks++; if (o !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h expected 00000080", o); end
    access(1'b0, 32'h44, 32'h0, 2'd1, 1'b1, lat, m, o);
    checks++; if (o !== 32'h00007F01) begin errors++; $display("FAIL lh: got %h expected 00007f01", o); end
    access(1'b0, 32'h46, 32'h0, 2'd1, 1'b0, lat, m, o);
    checks++; if (o !== 32'h000080FF) begin errors++; $display("FAIL lhu: got %h expected 000080ff", o); end
  endtask

  task automatic test_misalign();
    int lat; logic m; logic [31:0] o;
    access(1'b0, 32'h44, 32'h0, 2'd2, 1'b0, lat, m, o);
    access(1'b1, 32'h45, 32'hFFFFFFFF, 2'd2, 1'b0, lat, m, o);
    checks++; if (lat !== 1 || m !== 1'b1 || o !== 32'h80FF7F01) begin
      errors++; $display("FAIL mis_sw: lat=%0d mis=%b dout=%h expected 1/1/80ff7f01", lat, m, o); end
    access(1'b0, 32'h43, 32'h0, 2'd1, 1'b1, lat, m, o);
    checks++; if (lat !== 1 || m !== 1'b1 || o !== 32'h80FF7F01) begin
      errors++; $display("FAIL mis_lh: lat=%0d mis=%b dout=%h expected 1/1/80ff7f01", lat, m, o); end
    access(1'b1, 32'h44, 32'h0, 2'd3, 1'b0, lat, m, o);
    checks++; if (lat !== 1 || m !== 1'b1 || o !== 32'h80FF7F01) begin
      errors++; $display("FAIL mis_sz3: lat=%0d mis=%b dout=%h expected 1/1/80ff7f01", lat, m, o); end
    access(1'b0, 32'h44, 32'h0, 2'd2, 1'b0, lat, m, o);
    checks++; if (o !== 32'h80FF7F01 || m !== 1'b0) begin
      errors++; $display("FAIL mis_nowrite: got %h mis=%b expected 80ff7f01/0", o, m); end
  endtask

  task automatic test_back_to_back();
    int acks = 0; logic prev = 1'b0; int bad = 0; int lat; logic m; logic [31:0] o;
    while (busy) begin @(posedge clk); #1; end
    wr = 1'b0; addr = 32'h44; din = 32'h0; size = 2'd2; sgn = 1'b0; req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acks++;
        if (prev || dout !== 32'h80FF7F01) bad++;
      end
      prev = ack;
    end
    req = 1'b0;
    checks++; if (acks !== 4) begin errors++; $display("FAIL held_req_acks: got %0d expected 4", acks); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL held_req_data: got %0d bad acks expected 0", bad); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_req_idle: busy=%b expected 0", busy); end
    // Address wrap: 0x1008 aliases 0x008.
    access(1'b1, 32'h1008, 32'h5A5AC3C3, 2'd2, 1'b0, lat, m, o);
    model_store(32'h1008, 32'h5A5AC3C3, 2'd2);
    access(1'b0, 32'h0008, 32'h0, 2'd2, 1'b0, lat, m, o);
    checks++; if (o !== 32'h5A5AC3C3) begin errors++; $display("FAIL wrap: got %h expected 5a5ac3c3", o); end
  endtask

  task automatic test_latency0();
    int lat; logic m; logic [31:0] o;
    sel = 1'b1;
    access(1'b1, 32'h8, 32'hA5A50F0F, 2'd2, 1'b0, lat, m, o);
    checks++; if (lat !== 2 || m !== 1'b0) begin
      errors++; $display("FAIL l0_sw: lat=%0d mis=%b expected 2/0", lat, m); end
    access(1'b0, 32'h8, 32'h0, 2'd2, 1'b0, lat, m, o);
    checks++; if (lat !== 2 || o !== 32'hA5A50F0F) begin
      errors++; $display("FAIL l0_lw: lat=%0d dout=%h expected 2/a5a50f0f", lat, o); end
    access(1'b0, 32'hB, 32'h0, 2'd0, 1'b1, lat, m, o);
    checks++; if (o !== 32'hFFFFFFA5) begin errors++; $display("FAIL l0_lb: got %h expected ffffffa5", o); end
    access(1'b1, 32'h1, 32'h0, 2'd1, 1'b0, lat, m, o);
    checks++; if (lat !== 1 || m !== 1'b1) begin
      errors++; $display("FAIL l0_mis: lat=%0d mis=%b expected 1/1", lat, m); end
    access(1'b0, 32'h48, 32'h0, 2'd2, 1'b0, lat, m, o);
    checks++; if (o !== 32'hA5A50F0F) begin errors++; $display("FAIL l0_wrap: got %h expected a5a50f0f", o); end
    sel = 1'b0;
  endtask

  task automatic test_random();
    int lat; logic m; logic [31:0] o; logic [31:0] a, d, ed; logic [1:0] s; logic w, g, em;
    int el;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      access(1'b1, 32'h80 + 32'(4*i), d, 2'd2, 1'b0, lat, m, o);
      model_store(32'h80 + 32'(4*i), d, 2'd2);
    end
    access(1'b0, 32'h80, 32'h0, 2'd2, 1'b0, lat, m, o);
    ed = model_load(32'h80, 2'd2, 1'b0);
    for (int k = 0; k < 60; k++) begin
      a = 32'h80 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom << 12);
      s = 2'($urandom_range(0, 3)); w = 1'($urandom_range(0, 1));
      g = 1'($urandom_range(0, 1)); d = $urandom;
      em = model_mis(a, s);
      el = em ? 1 : 4;
      if (!em && !w) ed = model_load(a, s, g);
      access(w, a, d, s, g, lat, m, o);
      if (!em && w) model_store(a, d, s);
      checks++; if (lat !== el || m !== em) begin
        errors++; $display("FAIL rnd_ack[%0d]: lat=%0d mis=%b expected %0d/%b", k, lat, m, el, em); end
      checks++; if (o !== ed) begin
        errors++; $display("FAIL rnd_dout[%0d]: got %h expected %h (wr=%b a=%h sz=%0d)", k, o, ed, w, a, s); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_extension();
    test_misalign();
    test_back_to_back();
    test_latency0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
